// File: rtl/rx_phy_pkg.sv
// rx_phy_pkg: definitions shared by the phy_rx serial-to-parallel stage and
// the rx_byte_assembler.
//   COMMA_K28_5    - alignment/idle byte, never packed into words
//   BYTES_PER_WORD - bytes per assembled output word
//   rx_state_e     - byte assembler FSM encoding
package rx_phy_pkg;

  localparam logic [7:0] COMMA_K28_5    = 8'hBC;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    COLLECT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_byte_assembler.sv
// rx_byte_assembler: drops comma bytes from the recovered byte stream and
// packs the remaining bytes into 32-bit words (first byte in [31:24]).
// Only whole words are emitted.  A partial word that is cut short by a comma
// or by loss of link is dropped, and align_err is pulsed.
//
// Ports:
//   clk_f      - byte-rate clock
//   reset      - synchronous, active-low reset
//   data_in    - byte from the serial-to-parallel stage
//   valid_in   - data_in holds a valid byte this cycle
//   active_in  - upstream link aligned
//   data_out   - last assembled word; held until the next word
//   valid_out  - one-cycle pulse when data_out is loaded with a new word
//   align_err  - one-cycle pulse when a partial word is discarded
//   word_count - saturating count of emitted words (RX_WORD_CNT_EN only)
//
// Build option: define RX_WORD_CNT_EN to add the word_count port and counter.
module rx_byte_assembler
  import rx_phy_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_K28_5
) (
  input  logic                          clk_f,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  input  logic                          active_in,
  output logic [8*BYTES_PER_WORD-1:0]   data_out,
  output logic                          valid_out,
  output logic                          align_err
`ifdef RX_WORD_CNT_EN
  ,
  output logic [15:0]                   word_count
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  rx_state_e                        state_r, state_next_s;
  logic [1:0]                       idx_r, idx_next_s;
  // Holds the first three bytes of a word; the fourth goes straight to data_out.
  logic [23:0]                      buf_r, buf_next_s;
  logic [8*BYTES_PER_WORD-1:0]      data_out_r, data_out_next_s;
  logic                             valid_out_r, valid_out_next_s;
  logic                             align_err_r, align_err_next_s;
  logic                             byte_ok_s;

  // A usable byte is valid and is not a comma.
  assign byte_ok_s = valid_in && (data_in != COMMA);

  // Next-state, buffer and output computation.
  always_comb begin
    state_next_s     = state_r;
    idx_next_s       = idx_r;
    buf_next_s       = buf_r;
    data_out_next_s  = data_out_r;
    valid_out_next_s = 1'b0;
    align_err_next_s = 1'b0;

    if (!active_in) begin
      // Link loss beats everything else, including a completing word.
      state_next_s     = IDLE;
      idx_next_s       = 2'd0;
      align_err_next_s = (idx_r != 2'd0);
    end else begin
      case (state_r)
        IDLE: begin
          // The byte in the activation cycle is not accepted.
          state_next_s = HUNT;
        end
        HUNT: begin
          if (byte_ok_s) begin
            buf_next_s[23:16] = data_in;
            idx_next_s        = 2'd1;
            state_next_s      = COLLECT;
          end else begin
            idx_next_s = 2'd0;
          end
        end
        COLLECT: begin
          if (valid_in && (data_in == COMMA)) begin
            if (idx_r != 2'd0) begin
              // Comma inside a word means we were misaligned: restart.
              align_err_next_s = 1'b1;
              idx_next_s       = 2'd0;
              state_next_s     = HUNT;
            end else begin
              state_next_s = COLLECT;
            end
          end else if (byte_ok_s) begin
            case (idx_r)
              2'd0: buf_next_s[23:16] = data_in;
              2'd1: buf_next_s[15:8]  = data_in;
              2'd2: buf_next_s[7:0]   = data_in;
              default: begin
                data_out_next_s  = {buf_r, data_in};
                valid_out_next_s = 1'b1;
              end
            endcase
            idx_next_s = (idx_r == LAST_IDX) ? 2'd0 : idx_r + 2'd1;
          end else begin
            // Gap: hold buffer and index indefinitely.
            idx_next_s = idx_r;
          end
        end
        default: begin
          state_next_s = IDLE;
          idx_next_s   = 2'd0;
        end
      endcase
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk_f) begin
    if (!reset) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      buf_r       <= 24'd0;
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
      align_err_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      buf_r       <= buf_next_s;
      data_out_r  <= data_out_next_s;
      valid_out_r <= valid_out_next_s;
      align_err_r <= align_err_next_s;
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign align_err = align_err_r;

`ifdef RX_WORD_CNT_EN
  logic [15:0] word_cnt_r;

  // Saturating count of emitted words, stepped together with valid_out.
  always_ff @(posedge clk_f) begin
    if (!reset) begin
      word_cnt_r <= 16'd0;
    end else if (valid_out_next_s && (word_cnt_r != 16'hFFFF)) begin
      word_cnt_r <= word_cnt_r + 16'd1;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign word_count = word_cnt_r;
`endif

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Testbench for rx_byte_assembler: a table of byte steps with expected
// pulse flags; expected words go to a scoreboard queue when the completing
// byte is driven and are popped when valid_out is seen.
module tb_rx_byte_assembler;
  import rx_phy_pkg::*;

  logic        clk_f;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        active_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        align_err;
`ifdef RX_WORD_CNT_EN
  logic [15:0] word_count;
`endif

  int checks   = 0;
  int failures = 0;

  rx_byte_assembler dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .active_in (active_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .align_err (align_err)
`ifdef RX_WORD_CNT_EN
    ,
    .word_count(word_count)
`endif
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  typedef struct {
    logic        act;
    logic        vld;
    logic [7:0]  dat;
    logic        exp_vout;
    logic        exp_aerr;
    logic [31:0] exp_word;
  } step_t;

  step_t       tbl[$];
  logic [31:0] sb[$];
  logic [31:0] last_word;
  int          exp_count;

  task automatic add(input logic a, input logic v, input logic [7:0] d,
                     input logic ev, input logic ea, input logic [31:0] w);
    step_t s;
    s.act = a; s.vld = v; s.dat = d; s.exp_vout = ev; s.exp_aerr = ea; s.exp_word = w;
    tbl.push_back(s);
  endtask

  // Plain valid byte, no pulses expected.
  task automatic b(input logic [7:0] d);
    add(1'b1, 1'b1, d, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] w;
    reset     = 1'b0;
    data_in   = 8'd0;
    valid_in  = 1'b0;
    active_in = 1'b0;
    last_word = 32'd0;
    exp_count = 0;

    // Reset held 3 cycles with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_f);
      data_in   = (i == 1) ? 8'h44 : 8'hBC;
      valid_in  = 1'b1;
      active_in = (i != 0);
      @(posedge clk_f);
      #1;
      check("rst_data_out",  data_out,  32'd0);
      check("rst_valid_out", {31'd0, valid_out}, 32'd0);
      check("rst_align_err", {31'd0, align_err}, 32'd0);
`ifdef RX_WORD_CNT_EN
      check("rst_word_count", {16'd0, word_count}, 32'd0);
`endif
    end
    @(negedge clk_f);
    reset     = 1'b1;
    valid_in  = 1'b0;
    active_in = 1'b0;

    // Basic: activate, commas, then one word.
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
    b(8'hBC); b(8'hBC); b(8'h11); b(8'h22); b(8'h33);
    add(1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 32'h11223344);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
    // Back-to-back words at full rate.
    b(8'h01); b(8'h02); b(8'h03);
    add(1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 32'h01020304);
    b(8'h05); b(8'h06); b(8'h07);
    add(1'b1, 1'b1, 8'h08, 1'b1, 1'b0, 32'h05060708);
    // Comma between words is silent.
    b(8'hBC);
    // Gap in the middle of a word.
    b(8'hAA); b(8'hBB);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 8'hBC, 1'b0, 1'b0, 32'd0);
    b(8'hCC);
    add(1'b1, 1'b1, 8'hDD, 1'b1, 1'b0, 32'hAABBCCDD);
    // Comma inside a word.
    b(8'hAA); b(8'hBB);
    add(1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 32'd0);
    b(8'h01); b(8'h02); b(8'h03);
    add(1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 32'h01020304);
    // Link loss on the completing byte: no word, error pulse.
    b(8'h11); b(8'h22); b(8'h33);
    add(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 32'd0);
    // Valid bytes while idle or activating are ignored.
    add(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 32'd0);
    b(8'h77);
    b(8'hBC); b(8'h55); b(8'h66); b(8'h77);
    add(1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 32'h55667788);
    // Link loss at a word boundary raises no error.
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0);

    foreach (tbl[i]) begin
      @(negedge clk_f);
      active_in = tbl[i].act;
      valid_in  = tbl[i].vld;
      data_in   = tbl[i].dat;
      if (tbl[i].exp_vout) begin
        sb.push_back(tbl[i].exp_word);
        last_word = tbl[i].exp_word;
        exp_count++;
      end
      @(posedge clk_f);
      #1;
      check($sformatf("valid_out[%0d]", i), {31'd0, valid_out}, {31'd0, tbl[i].exp_vout});
      check($sformatf("align_err[%0d]", i), {31'd0, align_err}, {31'd0, tbl[i].exp_aerr});
      check($sformatf("data_out_hold[%0d]", i), data_out, last_word);
`ifdef RX_WORD_CNT_EN
      check($sformatf("word_count[%0d]", i), {16'd0, word_count}, exp_count);
`endif
      if (valid_out) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected[%0d]: got word %h expected none", i, data_out);
        end else begin
          w = sb.pop_front();
          check($sformatf("sb_word[%0d]", i), data_out, w);
        end
      end
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
